apb_requester: RTL

- APB4 initiator that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers toward up to four slaves.
- Drives the psel/penable/paddr/pwrite/pprot/pwdata/pstrb bus. Samples pready, prdata and pslverr, and returns a one-cycle response pulse with read data and error status.
- Sits between the system-side control logic and the APB slave fabric. It is the active driver the slaves respond to.

---
 rtl/apb_requester.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/apb_requester.sv
// APB4 initiator: converts a valid/ready command stream into SETUP/ACCESS transfers to four slaves.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_requester #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned SEL_LSB        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  input  logic [2:0]          cmd_prot,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [3:0]          psel,
  output logic                penable,
  output logic [ADDR_W-1:0]   paddr,
  output logic                pwrite,
  output logic [2:0]          pprot,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state_q, state_d;
  logic [3:0]          psel_d;
  logic                penable_d;
  logic [ADDR_W-1:0]   paddr_d;
  logic                pwrite_d;
  logic [2:0]          pprot_d;
  logic [DATA_W-1:0]   pwdata_d;
  logic [STRB_W-1:0]   pstrb_d;
  logic                rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_d;
  logic                rsp_err_d;
  logic                err_pend_q, err_pend_d;

  logic [1:0]          idx;
  logic                dec_err;
  logic                accept;
  logic                done;
  logic                timeout;

  assign idx       = cmd_addr[SEL_LSB +: 2];
  assign dec_err   = (cmd_addr >> (SEL_LSB + 2)) != '0;
  assign cmd_ready = (state_q == IDLE) || ((state_q == ACCESS) && pready);
  assign accept    = cmd_valid && cmd_ready;
  assign done      = (state_q == ACCESS) && pready;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Last tolerated wait cycle: terminating here makes TIMEOUT_CYCLES stalled cycles in total.
  assign timeout = (state_q == ACCESS) && !pready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP) begin
      cnt_d = '0;
    end else if ((state_q == ACCESS) && !pready && !timeout) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel;
    penable_d   = penable;
    paddr_d     = paddr;
    pwrite_d    = pwrite;
    pprot_d     = pprot;
    pwdata_d    = pwdata;
    pstrb_d     = pstrb;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    err_pend_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (err_pend_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (done) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = (!pwrite && !pslverr) ? prdata : '0;
          psel_d      = '0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end else if (timeout) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          psel_d      = '0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A decode error whose response slot is already taken is deferred by one cycle.
    if (accept) begin
      if (dec_err) begin
        psel_d    = '0;
        penable_d = 1'b0;
        state_d   = IDLE;
        if (rsp_valid_d) begin
          err_pend_d = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end else begin
        paddr_d   = cmd_addr;
        pwrite_d  = cmd_write;
        pprot_d   = cmd_prot;
        pwdata_d  = cmd_wdata;
        pstrb_d   = cmd_write ? cmd_strb : '0;
        psel_d    = 4'b0001 << idx;
        penable_d = 1'b0;
        state_d   = SETUP;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= IDLE;
      psel       <= '0;
      penable    <= 1'b0;
      paddr      <= '0;
      pwrite     <= 1'b0;
      pprot      <= '0;
      pwdata     <= '0;
      pstrb      <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      psel       <= psel_d;
      penable    <= penable_d;
      paddr      <= paddr_d;
      pwrite     <= pwrite_d;
      pprot      <= pprot_d;
      pwdata     <= pwdata_d;
      pstrb      <= pstrb_d;
      rsp_valid  <= rsp_valid_d;
      rsp_rdata  <= rsp_rdata_d;
      rsp_err    <= rsp_err_d;
      err_pend_q <= err_pend_d;
    end
  end

endmodule
